// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage and its timebase.
package pwm_pkg;

  localparam int PWM_CNT_W                = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_ZERO = 8'h00;
  localparam int PWM_PRESCALE_DIV_DEFAULT = 13;

  typedef enum logic [1:0] {
    OUT_LOW  = 2'd0,
    OUT_HIGH = 2'd1,
    OUT_PWM  = 2'd2
  } out_mode_e;

  // Full-scale duty is special-cased so the output never drops for one tick at the wrap.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

  function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
    if (!en_out)      return OUT_LOW;
    else if (!en_pwm) return OUT_HIGH;
    else              return OUT_PWM;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM timebase: tick counter, period-boundary strobe and a
// period_start pulse aligned with the registered outputs of the consumer.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = PWM_PRESCALE_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] tick_cnt,
  output logic                 wrap,
  output logic                 period_start
);

  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

  logic [PRE_W-1:0] prescale_cnt;
  logic             tick;
  logic             first_q;
  logic             wrap_q;

  assign tick = (prescale_cnt == PRE_W'(PRESCALE_DIV - 1));
  assign wrap = first_q | (tick & (tick_cnt == '1));

  // NOTE: reset is synchronous (sampled only at the clock edge) and all state uses <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_cnt <= '0;
      tick_cnt     <= '0;
      first_q      <= 1'b1;
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      first_q      <= 1'b0;
      wrap_q       <= wrap;
      period_start <= wrap_q;
      // Counters hold during the post-reset boundary so the first period starts at tick 0.
      if (!first_q) begin
        prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
        if (tick) tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives N_OUT user outputs as low, static high or PWM; duty and PWM enables are
// shadowed at period boundaries so every period is a complete, glitch-free waveform.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int N_OUT        = 16,
  parameter int PRESCALE_DIV = PWM_PRESCALE_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_OUT-1:0]     en_reg_out,
  input  logic [N_OUT-1:0]     en_reg_pwm,
  input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
  output logic [N_OUT-1:0]     pwm_out,
  output logic                 period_start
);

  logic [PWM_CNT_W-1:0] tick_cnt;
  logic                 wrap;
  logic [PWM_CNT_W-1:0] duty_shadow;
  logic [N_OUT-1:0]     pwm_en_shadow;
  logic                 level;
  logic [N_OUT-1:0]     pwm_next;

  pwm_timebase #(.PRESCALE_DIV(PRESCALE_DIV)) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .tick_cnt     (tick_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow   <= PWM_DUTY_ZERO;
      pwm_en_shadow <= '0;
    end else if (wrap) begin
      duty_shadow   <= pwm_duty_cycle;
      pwm_en_shadow <= en_reg_pwm;
    end
  end

  assign level = pwm_level(tick_cnt, duty_shadow);

  // en_reg_out is used live so disabling an output takes effect mid-period.
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    out_mode_e mode;
    assign mode        = out_mode(en_reg_out[i], pwm_en_shadow[i]);
    assign pwm_next[i] = (mode == OUT_PWM) ? level : (mode == OUT_HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) pwm_out <= '0;
    else     pwm_out <= pwm_next;
  end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: a fast (PRESCALE_DIV=1) and a default (13) instance
// share stimulus; a period-arithmetic model is compared every cycle, plus literal checks.
module tb_pwm_output_stage;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      en_out = '0;
  logic [15:0]      en_pwm = '0;
  logic [7:0]       duty = '0;
  logic [1:0][15:0] pout;
  logic [1:0]       ps;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_output_stage #(.N_OUT(16), .PRESCALE_DIV(1)) dut_fast (
    .clk(clk), .rst(rst), .en_reg_out(en_out), .en_reg_pwm(en_pwm),
    .pwm_duty_cycle(duty), .pwm_out(pout[0]), .period_start(ps[0])
  );

  pwm_output_stage #(.N_OUT(16), .PRESCALE_DIV(13)) dut_slow (
    .clk(clk), .rst(rst), .en_reg_out(en_out), .en_reg_pwm(en_pwm),
    .pwm_duty_cycle(duty), .pwm_out(pout[1]), .period_start(ps[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 13;
  endfunction

  // Model: the output after the m-th non-reset edge shows period clock c = m-2;
  // shadows load at edges m = 1 + k*256*DIV.
  int          m_cnt [2];
  logic [15:0] sh_en [2];
  logic [7:0]  sh_duty [2];
  logic [15:0] exp_out [2];
  logic        exp_ps [2];
  logic        model_live = 1'b0;

  always @(posedge clk) begin
    int m, p, c, pos, tk;
    logic lvl;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_cnt[d]   <= 0;
        sh_en[d]   <= '0;
        sh_duty[d] <= '0;
        exp_out[d] <= '0;
        exp_ps[d]  <= 1'b0;
        model_live <= 1'b1;
      end else begin
        m   = m_cnt[d] + 1;
        p   = 256 * div_of(d);
        c   = m - 2;
        pos = (c < 0) ? 0 : c % p;
        tk  = pos / div_of(d);
        lvl = (sh_duty[d] == 8'hFF) || (tk < int'(sh_duty[d]));
        m_cnt[d]   <= m;
        exp_ps[d]  <= (c >= 0) && (pos == 0);
        exp_out[d] <= (en_out & ~sh_en[d]) | (en_out & sh_en[d] & {16{lvl}});
        if ((m - 1) % p == 0) begin
          sh_en[d]   <= en_pwm;
          sh_duty[d] <= duty;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model pwm_out[dut%0d]", d), pout[d], exp_out[d]);
        check($sformatf("model period_start[dut%0d]", d), ps[d], exp_ps[d]);
      end
    end
  end

  task automatic wait_ps(input int which, input int budget);
    int n = 0;
    @(negedge clk);
    while (!ps[which] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ps[which]) check($sformatf("wait_ps[dut%0d] timeout", which), ps[which], 1);
  endtask

  // Called on a period_start sample; returns on the next period_start sample.
  task automatic count_period(input int which, output int len, output int highs, output logic tail);
    int n = 0;
    len   = 1;
    highs = pout[which][0];
    tail  = pout[which][0];
    forever begin
      @(negedge clk);
      if (ps[which]) break;
      len++;
      highs += pout[which][0];
      tail = pout[which][0];
      n++;
      if (n > 5000) begin
        check($sformatf("count_period[dut%0d] timeout", which), ps[which], 1);
        break;
      end
    end
  endtask

  initial begin
    int len, highs;
    logic tail;

    // Reset with all inputs low.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pwm_out", pout[0], 16'h0000);
    check("reset period_start", ps[0], 1'b0);
    rst = 1'b0;

    // Static high outputs, then a mid-period disable.
    repeat (5) @(negedge clk);
    en_out = 16'hFFFF;
    @(negedge clk);
    check("static high fast", pout[0], 16'hFFFF);
    check("static high slow", pout[1], 16'hFFFF);
    en_out = 16'h00F0;
    @(negedge clk);
    check("disable mid-period fast", pout[0], 16'h00F0);
    check("disable mid-period slow", pout[1], 16'h00F0);

    // Reset mid-period with all inputs high.
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'hFF;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("in-reset pwm_out fast", pout[0], 16'h0000);
      check("in-reset pwm_out slow", pout[1], 16'h0000);
      check("in-reset period_start fast", ps[0], 1'b0);
      check("in-reset period_start slow", ps[1], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("boundary clk period_start", ps[0], 1'b0);
    @(negedge clk);
    check("first period_start fast", ps[0], 1'b1);
    check("first period_start slow", ps[1], 1'b1);

    // 50% duty at PRESCALE_DIV=1.
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(0, 600);
    wait_ps(0, 600);
    check("50% rises on period_start", pout[0][0], 1'b1);
    count_period(0, len, highs, tail);
    check("50% period length", len, 256);
    check("50% high clks", highs, 128);
    check("50% low before wrap", tail, 1'b0);
    check("50% rises on next period_start", pout[0][0], 1'b1);

    // Duty extremes over two periods each.
    duty = 8'h00;
    wait_ps(0, 600);
    wait_ps(0, 600);
    for (int k = 0; k < 2; k++) begin
      count_period(0, len, highs, tail);
      check("duty 0x00 high clks", highs, 0);
    end
    duty = 8'hFF;
    wait_ps(0, 600);
    wait_ps(0, 600);
    for (int k = 0; k < 2; k++) begin
      count_period(0, len, highs, tail);
      check("duty 0xFF high clks", highs, 256);
      check("duty 0xFF no dropout at wrap", pout[0][0], 1'b1);
    end

    // Mid-period duty write is deferred to the next period.
    duty = 8'h40;
    wait_ps(0, 600);
    wait_ps(0, 600);
    len   = 1;
    highs = pout[0][0];
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      len++;
      highs += pout[0][0];
    end
    duty = 8'hC0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ps[0]) break;
      len++;
      highs += pout[0][0];
    end
    check("update period length", len, 256);
    check("update current period high", highs, 64);
    count_period(0, len, highs, tail);
    check("update next period high", highs, 192);

    // Default prescaler: period spacing and a one-tick pulse.
    duty = 8'h01;
    wait_ps(1, 8000);
    wait_ps(1, 8000);
    for (int k = 0; k < 2; k++) begin
      count_period(1, len, highs, tail);
      check("prescaled period spacing", len, 3328);
      check("prescaled duty 0x01 high clks", highs, 13);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
